// File: rtl/mod_op_sequencer.sv
// Sparse dot-product sequencer: gathers D[offset+X[idx+i]] * W[woff+i] in Q8.8,
// accumulates, saturates, applies an activation and writes one result word.
module mod_op_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        fsmBeginOp,
  output logic        fsmReadyForNextOp,
  output logic        critical,
  input  logic [15:0] offsetReg,
  input  logic [15:0] indexOffsetReg,
  input  logic [15:0] weightOffsetReg,
  input  logic [15:0] destReg,
  input  logic [15:0] numOpsReg,
  input  logic [1:0]  actFuncSel,
  output logic [15:0] memAddr,
  input  logic [15:0] memRdData,
  output logic [15:0] memWrData,
  output logic        memWE
);

  localparam int unsigned DW = 16;
  localparam int unsigned PW = 32;
  localparam int unsigned AW = 40;
  localparam logic signed [AW-1:0] SAT_MAX = AW'(32767);
  localparam logic signed [AW-1:0] SAT_MIN = AW'(-32768);

  typedef enum logic [2:0] {IDLE, S_IDX, S_DAT, S_WGT, S_MAC, S_ACT, S_WR} state_t;

  state_t                 state, state_n;
  logic [DW-1:0]          offset_q, offset_n;
  logic [DW-1:0]          index_off_q, index_off_n;
  logic [DW-1:0]          weight_off_q, weight_off_n;
  logic [DW-1:0]          dest_q, dest_n;
  logic [DW-1:0]          num_ops_q, num_ops_n;
  logic [1:0]             act_sel_q, act_sel_n;
  logic signed [AW-1:0]   acc, acc_n;
  logic [DW-1:0]          idx, idx_n;
  logic [DW-1:0]          data_val, data_val_n;
  logic [DW-1:0]          result, result_n;
  logic signed [PW-1:0]   prod;
  logic signed [PW-1:0]   term;
  logic signed [DW-1:0]   sat_r;

  // State and datapath registers; handshake/write outputs decode the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      offset_q          <= '0;
      index_off_q       <= '0;
      weight_off_q      <= '0;
      dest_q            <= '0;
      num_ops_q         <= '0;
      act_sel_q         <= '0;
      acc               <= '0;
      idx               <= '0;
      data_val          <= '0;
      result            <= '0;
      fsmReadyForNextOp <= 1'b1;
      critical          <= 1'b0;
      memWE             <= 1'b0;
      memWrData         <= '0;
    end else begin
      state             <= state_n;
      offset_q          <= offset_n;
      index_off_q       <= index_off_n;
      weight_off_q      <= weight_off_n;
      dest_q            <= dest_n;
      num_ops_q         <= num_ops_n;
      act_sel_q         <= act_sel_n;
      acc               <= acc_n;
      idx               <= idx_n;
      data_val          <= data_val_n;
      result            <= result_n;
      fsmReadyForNextOp <= (state_n == IDLE);
      critical          <= (state_n != IDLE);
      memWE             <= (state_n == S_WR);
      memWrData         <= (state_n == S_WR) ? result_n : '0;
    end
  end

  // Next state, datapath updates and the cache address (combinational: the
  // data address depends on read data arriving in the same cycle)
  always_comb begin
    state_n      = state;
    offset_n     = offset_q;
    index_off_n  = index_off_q;
    weight_off_n = weight_off_q;
    dest_n       = dest_q;
    num_ops_n    = num_ops_q;
    act_sel_n    = act_sel_q;
    acc_n        = acc;
    idx_n        = idx;
    data_val_n   = data_val;
    result_n     = result;
    memAddr      = '0;

    prod = PW'($signed(data_val)) * PW'($signed(memRdData));
    term = prod >>> 8;

    if (acc > SAT_MAX)      sat_r = 16'sh7FFF;
    else if (acc < SAT_MIN) sat_r = 16'sh8000;
    else                    sat_r = acc[DW-1:0];

    unique case (state)
      IDLE: begin
        if (fsmBeginOp) begin
          offset_n     = offsetReg;
          index_off_n  = indexOffsetReg;
          weight_off_n = weightOffsetReg;
          dest_n       = destReg;
          num_ops_n    = numOpsReg;
          act_sel_n    = actFuncSel;
          acc_n        = '0;
          idx_n        = '0;
          state_n      = (numOpsReg == '0) ? S_ACT : S_IDX;
        end
      end
      S_IDX: begin
        memAddr = index_off_q + idx;
        state_n = S_DAT;
      end
      S_DAT: begin
        memAddr = offset_q + memRdData;
        state_n = S_WGT;
      end
      S_WGT: begin
        memAddr    = weight_off_q + idx;
        data_val_n = memRdData;
        state_n    = S_MAC;
      end
      S_MAC: begin
        acc_n   = acc + AW'(term);
        idx_n   = idx + 16'd1;
        state_n = (idx == num_ops_q - 16'd1) ? S_ACT : S_IDX;
      end
      S_ACT: begin
        unique case (act_sel_q)
          2'd0: result_n = sat_r;
          2'd1: result_n = sat_r[DW-1] ? '0 : sat_r;
          2'd2: result_n = (sat_r > 16'sd0) ? 16'h0100 : '0;
          default: begin
            if (sat_r < -16'sd256)     result_n = 16'hFF00;
            else if (sat_r > 16'sd256) result_n = 16'h0100;
            else                       result_n = sat_r;
          end
        endcase
        state_n = S_WR;
      end
      S_WR: begin
        memAddr = dest_q;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/mod_op_sequencer.md
MOD_OP_SEQUENCER -- requirements
Module: mod_op_sequencer

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port fsmBeginOp, input, 1 bit: start pulse from the control registers.
REQ-004 The block SHALL have port fsmReadyForNextOp, output, 1 bit: high when idle.
REQ-005 The block SHALL have port critical, output, 1 bit: high while busy, blocking control-register writes.
REQ-006 The block SHALL have ports offsetReg, indexOffsetReg, weightOffsetReg, destReg and numOpsReg, each input, 16 bits: data base, index base, weight base, result address and term count.
REQ-007 The block SHALL have port actFuncSel, input, 2 bits: activation select.
REQ-008 The block SHALL have port memAddr, output, 16 bits: cache address.
REQ-009 The block SHALL have port memRdData, input, 16 bits: cache read data, valid one cycle after memAddr.
REQ-010 The block SHALL have port memWrData, output, 16 bits: result write data.
REQ-011 The block SHALL have port memWE, output, 1 bit: one-cycle write strobe.

Function
REQ-012 Operation: the block SHALL compute result = act(sat16(sum over i=0..numOps-1 of (D[offsetReg+X[indexOffsetReg+i]] * W[weightOffsetReg+i]) >>> 8)), with all operands signed Q8.8.
REQ-013 The block SHALL use states IDLE, S_IDX, S_DAT, S_WGT, S_MAC, S_ACT and S_WR.
REQ-014 In IDLE with fsmBeginOp=1, the block SHALL snapshot all six operand inputs, clear acc and i, and go to S_IDX; if numOps==0 it SHALL go to S_ACT instead.
REQ-015 While not in IDLE, fsmBeginOp SHALL be ignored.
REQ-016 In S_IDX, memAddr SHALL be indexOffset+i.
REQ-017 In S_DAT, memAddr SHALL be offset+memRdData.
REQ-018 In S_WGT, memAddr SHALL be weightOffset+i, and dataVal SHALL be latched from memRdData.
REQ-019 In S_MAC, acc SHALL be updated to acc + ((dataVal*memRdData) >>> 8) and i SHALL increment.
REQ-020 From S_MAC, the next state SHALL be S_ACT if i==numOps-1, else S_IDX.
REQ-021 All address sums SHALL be 16-bit with wrap-around modulo 2^16, and no error SHALL be raised on wrap.
REQ-022 The product SHALL be 32-bit signed with an arithmetic shift, and acc SHALL be 40-bit signed with no overflow over 65535 terms.
REQ-023 In S_ACT, the block SHALL compute r = acc saturated to [0x8000, 0x7FFF], then register result per actFuncSel: 0 = r; 1 = ReLU (r<0 gives 0); 2 = step (r>0 gives 0x0100, else 0); 3 = clamp r to [0xFF00, 0x0100].
REQ-024 In S_WR, memAddr SHALL be destReg, memWrData SHALL be result and memWE SHALL be 1, then the block SHALL return to IDLE.
REQ-025 Outside S_WR, memWE SHALL be 0 and memWrData SHALL be 0.
REQ-026 In IDLE, memAddr SHALL be 0.
REQ-027 fsmReadyForNextOp SHALL equal (state==IDLE), and critical SHALL equal its inverse, both as registered state decode.
REQ-028 Timing: with fsmBeginOp accepted at edge 0, a term takes 4 cycles, S_WR SHALL occur in cycle 4N+2 and IDLE SHALL be reached in cycle 4N+3; for N=0, S_WR SHALL occur in cycle 2.
REQ-029 Back-to-back: fsmBeginOp in the first IDLE cycle after S_WR SHALL be accepted.

Reset
REQ-030 When rst=1, at the next edge state SHALL be IDLE; acc, i, dataVal, result and the snapshots SHALL be 0; memWE SHALL be 0, critical SHALL be 0 and fsmReadyForNextOp SHALL be 1.
REQ-031 Reset SHALL override fsmBeginOp in the same cycle.
REQ-032 Reset mid-operation SHALL abort with no write issued.
REQ-033 The block SHALL take no action while rst is held.

Verification
REQ-034 Basic dot product: X[0x10]=0, X[0x11]=1; D[0x20]=0x0200, D[0x21]=0x0100; W[0x30]=0x0180, W[0x31]=0xFF00; numOps=2; actFuncSel=0; dest=0x40 -> write 0x0200 to 0x40 in cycle 10, fsmReadyForNextOp=1 in cycle 11.
REQ-035 ReLU and step: same setup with both weights 0xFF00 (acc = -3.0) -> actFuncSel=1 writes 0x0000; actFuncSel=2 writes 0x0000; actFuncSel=3 writes 0xFF00.
REQ-036 Saturation: numOps=1, D=0x7F00, W=0x7F00 -> write 0x7FFF; repeat with W=0x8100 -> write 0x8000.
REQ-037 numOps=0 with dest=0x55 -> write 0x0000 to 0x55 in cycle 2, with no memory reads issued.
REQ-038 Address wrap: indexOffset=0xFFFF, numOps=2 -> index reads at 0xFFFF then 0x0000.
REQ-039 Abort and ignore: rst asserted in the S_MAC of term 0 of a 3-term op -> IDLE next cycle, memWE never asserted, critical=0; fsmBeginOp pulsed while busy -> no effect on operands or timing.
